// File: rtl/serial_sub_recover_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// master drives the request side; slave is the subtractor itself.
interface serial_sub_recover_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] add_in;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             busy;
    logic             done;

    modport master (
        output start, sum_in, add_in,
        input  diff, borrow, busy, done
    );

    modport slave (
        input  start, sum_in, add_in,
        output diff, borrow, busy, done
    );
endinterface

// File: rtl/serial_sub_recover.sv
// Bit-serial subtractor recovering the unknown addend as sum - addend, LSB first,
// with an unsigned borrow flag that marks a wrapped addition.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | one difference bit per clock, WIDTH clocks
// DONE  | one-cycle done pulse, result just loaded
module serial_sub_recover #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_sub_recover_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_br_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    // Full-subtractor cell on the current LSBs; result fills from the MSB end.
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.sum_in;
                        r_b     <= bus.add_in;
                        r_res   <= '0;
                        r_br    <= 1'b0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_nxt;
                    r_br    <= w_br_nxt;
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        r_diff   <= w_res_nxt;
                        r_borrow <= w_br_nxt;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_serial_sub_recover.sv
// Directed bench for serial_sub_recover: vector table of subtractions plus
// hand-written sequences for ignored start, input changes and mid-op reset.
module tb_serial_sub_recover;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_sub_recover_if #(.WIDTH(WIDTH)) bus ();

    serial_sub_recover #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s;
        logic [7:0] a;
        logic [7:0] d;
        logic       b;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] s, input logic [7:0] a,
                          input logic [7:0] exp_d, input logic exp_b,
                          input string tag);
        logic [7:0] prev_d;
        logic       prev_b;
        int         lat;
        int         busy_cnt;
        int         stable;
        bus.sum_in = s;
        bus.add_in = a;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        prev_d   = bus.diff;
        prev_b   = bus.borrow;
        lat      = 0;
        busy_cnt = 0;
        stable   = 1;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            if (bus.diff !== prev_d || bus.borrow !== prev_b) stable = 0;
            tick();
            lat++;
        end
        chk($sformatf("%s latency", tag), lat, WIDTH);
        chk($sformatf("%s busy_cycles", tag), busy_cnt, WIDTH);
        chk($sformatf("%s out_stable", tag), stable, 1);
        chk($sformatf("%s busy_at_done", tag), int'(bus.busy), 0);
        chk($sformatf("%s diff", tag), int'(bus.diff), int'(exp_d));
        chk($sformatf("%s borrow", tag), int'(bus.borrow), int'(exp_b));
        tick();
        chk($sformatf("%s done_width", tag), int'(bus.done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;
        int lat;

        checks = 0;
        errors = 0;

        vecs[0] = '{s: 8'd200, a: 8'd55,  d: 8'd145, b: 1'b0};
        vecs[1] = '{s: 8'd10,  a: 8'd20,  d: 8'd246, b: 1'b1};
        vecs[2] = '{s: 8'd255, a: 8'd255, d: 8'd0,   b: 1'b0};
        vecs[3] = '{s: 8'd0,   a: 8'd1,   d: 8'd255, b: 1'b1};
        vecs[4] = '{s: 8'd128, a: 8'd1,   d: 8'd127, b: 1'b0};
        vecs[5] = '{s: 8'd1,   a: 8'd255, d: 8'd2,   b: 1'b1};
        vecs[6] = '{s: 8'd37,  a: 8'd200, d: 8'd93,  b: 1'b1};
        vecs[7] = '{s: 8'd0,   a: 8'd0,   d: 8'd0,   b: 1'b0};
        vecs[8] = '{s: 8'd100, a: 8'd40,  d: 8'd60,  b: 1'b0};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.sum_in = '0;
        bus.add_in = '0;

        for (int i = 0; i < 5; i++) begin
            if (i == 2) rst = 1'b0;
            tick();
            chk($sformatf("reset diff c%0d", i), int'(bus.diff), 0);
            chk($sformatf("reset borrow c%0d", i), int'(bus.borrow), 0);
            chk($sformatf("reset busy c%0d", i), int'(bus.busy), 0);
            chk($sformatf("reset done c%0d", i), int'(bus.done), 0);
        end

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].d, vecs[i].b, $sformatf("vec%0d", i));
        end

        // start re-pulsed during SHIFT must be dropped, not queued
        bus.sum_in = 8'd200;
        bus.add_in = 8'd55;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        tick();
        bus.sum_in = 8'd9;
        bus.add_in = 8'd3;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                n_done++;
                chk("busy_start diff", int'(bus.diff), 145);
                chk("busy_start borrow", int'(bus.borrow), 0);
            end
            chk($sformatf("busy_start overlap c%0d", i), int'(bus.busy & bus.done), 0);
            tick();
        end
        chk("busy_start done_count", n_done, 1);
        chk("busy_start final diff", int'(bus.diff), 145);

        // inputs wiggle after acceptance; result must follow the captured pair
        bus.sum_in = 8'd100;
        bus.add_in = 8'd40;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            bus.sum_in = 8'($urandom);
            bus.add_in = 8'($urandom);
            tick();
            lat++;
        end
        chk("inchg latency", lat, WIDTH);
        chk("inchg diff", int'(bus.diff), 60);
        chk("inchg borrow", int'(bus.borrow), 0);
        tick();

        // reset in the middle of an operation
        bus.sum_in = 8'd200;
        bus.add_in = 8'd55;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        tick();
        tick();
        tick();
        chk("midrst busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", int'(bus.busy), 0);
        chk("midrst done", int'(bus.done), 0);
        chk("midrst diff", int'(bus.diff), 0);
        chk("midrst borrow", int'(bus.borrow), 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) n_done++;
        end
        chk("midrst no_activity", n_done, 0);

        run_op(8'd7, 8'd7, 8'd0, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_sub_recover.md
Name: serial_sub_recover

Overview:
- Bit-serial subtractor: the inverse of the team's `ui_in + uio_in` byte-adder datapath.
- Given a captured sum and one known addend, recovers the other operand as `sum - addend` (mod 2^WIDTH), one bit per clock, LSB first.
- Sits beside the adder in the tile top and is driven by a simple start/done handshake.
- Also reports the unsigned borrow, flagging sum < addend, i.e. the original addition wrapped.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..16

Ports:
clk      input   1      rising-edge clock, single clock domain
rst      input   1      synchronous reset, active-high
start    input   1      request; sampled only in IDLE
sum_in   input   WIDTH  minuend, captured on accepted start
add_in   input   WIDTH  subtrahend, captured on accepted start
diff     output  WIDTH  result sum_in - add_in mod 2^WIDTH, registered
borrow   output  1      1 when sum_in < add_in (unsigned), registered
busy     output  1      high while serial operation in progress
done     output  1      one-cycle pulse when diff/borrow become valid

Behaviour:
- Clocking and reset:
  - One clock `clk`; reset is synchronous and active-high (`rst`); all state changes on rising clk.
  - While rst=1 at an edge: state=IDLE, count=0, internal shift regs=0, diff=0, borrow=0, busy=0, done=0.
  - Reset mid-operation aborts the op; no done pulse; diff/borrow return to 0.
- States:
  - IDLE: busy=0, done=0.
    - start=1 at edge k: capture sum_in/add_in into shift regs a/b; clear working result and carry-borrow bit br=0; count=0; go SHIFT.
    - start=0: stay in IDLE.
  - SHIFT: busy=1.
    - Each edge computes d = a[0] ^ b[0] ^ br and br' = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br).
    - Shifts d into the result MSB (result shifts right); shifts a and b right; count++.
    - On the edge where count==WIDTH-1: load diff with the completed result word, borrow with br'; go DONE.
  - DONE: busy=0, done=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- Latency:
  - start sampled at edge k; SHIFT covers edges k+1..k+WIDTH; done high in the cycle following edge k+WIDTH.
  - Earliest next start is sampled at edge k+WIDTH+2, so throughput is one result per WIDTH+2 cycles.
- start handling:
  - start asserted during SHIFT or DONE is ignored, not queued; the bench must re-assert it in IDLE.
  - start is level-sampled: held high continuously, it re-triggers on every IDLE cycle.
- Input capture: sum_in/add_in are only observed at the accepting edge; later changes do not affect the running operation.
- Output stability:
  - diff/borrow hold their last result through IDLE and the whole of the next operation.
  - They update only on entry to DONE; no partial results are ever visible.
- Arithmetic:
  - Result is modular; borrow equals the final borrow-out, identical to the carry-out of the matching WIDTH-bit add being 1.
  - Equal operands give diff=0, borrow=0.
- Invariants:
  - busy and done are never both 1.
  - done never lasts more than 1 cycle.

Test Plan:
- Reset then idle, WIDTH=8: rst=1 for 2 cycles, start=0 -> diff=0, borrow=0, busy=0, done=0 throughout.
- sum_in=200, add_in=55, start for 1 cycle -> busy=1 for 8 cycles; done pulse 8 cycles after the accepting edge; diff=145, borrow=0.
- sum_in=10, add_in=20 -> diff=246, borrow=1. Then 255-255 -> diff=0, borrow=0. Then 0-1 -> diff=255, borrow=1.
- Start while busy: start 200-55, re-pulse start with 9-3 at SHIFT cycle 3 -> single done with diff=145; no second done until start is re-asserted in IDLE.
- Input change during op: after accepting 100-40, change sum_in/add_in every cycle -> diff=60, borrow=0.
- Reset mid-op: rst=1 at SHIFT cycle 4 of 200-55 -> next cycle busy=0, diff=0, borrow=0, no done. A fresh 7-7 then yields diff=0, borrow=0 with normal latency.
